resp_framer: RTL and testbench

- Transmit-side counterpart of the command receive path.
- Accepts status/event words from the command processor and glitch logic (e.g. "armed", "fired", "trigger seen") and buffers them in a small FIFO.
- Serialises each event as a fixed-length framed packet of bytes into the existing uart_tx byte handshake on the 10 MHz UART clock.

---
 rtl/resp_pkg.sv | 22 ++
 rtl/resp_framer_if.sv | 26 ++
 rtl/resp_fifo.sv | 41 ++++
 rtl/resp_framer.sv | 130 +++++++++++++
 tb/tb_resp_framer.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/resp_pkg.sv
// Shared types and constants for the event response framer.
package resp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  localparam int FRAME_LEN_BASE = 7;
  localparam int FRAME_LEN_SEQ  = 8;
  localparam int IDX_W          = 3;
  localparam int EVT_W          = 40;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // XOR of the code byte and the four payload bytes of a queued event.
  function automatic logic [7:0] evt_xor(input logic [EVT_W-1:0] evt);
    return evt[39:32] ^ evt[31:24] ^ evt[23:16] ^ evt[15:8] ^ evt[7:0];
  endfunction

endpackage

// File: rtl/resp_framer_if.sv
// Event push and uart_tx byte handshake bundle for resp_framer.
interface resp_framer_if;
  // Event side: i_evt_valid is a one-cycle push with no back-pressure; a push
  // seen while o_evt_full is high is dropped. Tx side: o_tx_dv is a one-cycle
  // strobe, o_tx_byte stays stable until uart_tx answers with an i_tx_done pulse.
  logic        i_evt_valid;
  logic [7:0]  i_evt_code;
  logic [31:0] i_evt_data;
  logic        o_evt_full;
  logic        o_tx_dv;
  logic [7:0]  o_tx_byte;
  logic        i_tx_done;
  logic        o_busy;
  logic [7:0]  o_drop_count;
  logic [7:0]  o_timeout_count;

  modport master (
    input  i_evt_valid, i_evt_code, i_evt_data, i_tx_done,
    output o_evt_full, o_tx_dv, o_tx_byte, o_busy, o_drop_count, o_timeout_count
  );

  modport slave (
    output i_evt_valid, i_evt_code, i_evt_data, i_tx_done,
    input  o_evt_full, o_tx_dv, o_tx_byte, o_busy, o_drop_count, o_timeout_count
  );
endinterface

// File: rtl/resp_fifo.sv
// Synchronous event FIFO; full/empty resolved with an extra pointer bit.
module resp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 40
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/resp_framer.sv
// Frames queued status events into SYNC/[SEQ]/code/data/CHK byte packets for uart_tx.
// Optional macro RESP_SEQNUM_EN inserts a per-frame sequence byte after SYNC.
module resp_framer
  import resp_pkg::*;
#(
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] SYNC_BYTE    = SYNC_DEFAULT,
  parameter int         DONE_TIMEOUT = 4095
) (
  input  logic                          clk,
  input  logic                          reset,
  resp_framer_if.master                 bus,
  output state_t                        dbg_state,
  output logic [$clog2(FIFO_DEPTH):0]   dbg_level
);
`ifdef RESP_SEQNUM_EN
  localparam int FRAME_LEN = FRAME_LEN_SEQ;
`else
  localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif
  localparam int HDR = FRAME_LEN - 6;
  localparam int TW  = $clog2(DONE_TIMEOUT + 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TW-1:0]      timer_q;
  logic [7:0]         frame_q [FRAME_LEN_SEQ];
  logic [7:0]         load_bytes [FRAME_LEN_SEQ];
  logic [7:0]         drop_q, tmo_q;
  logic [EVT_W-1:0]   head;
  logic               fifo_full, fifo_empty, pop, drop, tmo_hit, last_byte;
  logic [7:0]         chk;
`ifdef RESP_SEQNUM_EN
  logic [7:0]         seq_q;
`endif

  assign pop       = (state_q == ST_LOAD);
  assign drop      = bus.i_evt_valid && fifo_full;
  assign last_byte = (idx_q == IDX_W'(FRAME_LEN - 1));
  assign tmo_hit   = (state_q == ST_WAIT) && !bus.i_tx_done && (timer_q == TW'(DONE_TIMEOUT - 1));

  resp_fifo #(.DEPTH(FIFO_DEPTH), .W(EVT_W)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.i_evt_valid),
    .pop   (pop),
    .wdata ({bus.i_evt_code, bus.i_evt_data}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (dbg_level)
  );

  // Frame image built from the FIFO head; captured only in LOAD.
  always_comb begin
    for (int i = 0; i < FRAME_LEN_SEQ; i++) load_bytes[i] = 8'h00;
    chk = evt_xor(head);
    load_bytes[0] = SYNC_BYTE;
`ifdef RESP_SEQNUM_EN
    load_bytes[1] = seq_q;
    chk = chk ^ seq_q;
`endif
    for (int i = 0; i < 5; i++) load_bytes[HDR + i] = head[39 - 8*i -: 8];
    load_bytes[FRAME_LEN - 1] = chk;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_LOAD;
      ST_LOAD: begin
        idx_d   = '0;
        state_d = ST_SEND;
      end
      ST_SEND: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.i_tx_done) begin
          if (last_byte) begin
            state_d = fifo_empty ? ST_IDLE : ST_LOAD;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_SEND;
          end
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      timer_q <= '0;
      drop_q  <= 8'h00;
      tmo_q   <= 8'h00;
      for (int i = 0; i < FRAME_LEN_SEQ; i++) frame_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (state_q == ST_SEND)      timer_q <= '0;
      else if (state_q == ST_WAIT) timer_q <= timer_q + TW'(1);
      if (drop && drop_q != 8'hFF)   drop_q <= drop_q + 8'd1;
      if (tmo_hit && tmo_q != 8'hFF) tmo_q  <= tmo_q + 8'd1;
      if (pop) begin
        for (int i = 0; i < FRAME_LEN_SEQ; i++) frame_q[i] <= load_bytes[i];
      end
    end
  end

`ifdef RESP_SEQNUM_EN
  // Advances on every LOAD, so frames later aborted still consume a number.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    seq_q <= 8'h00;
    else if (pop) seq_q <= seq_q + 8'd1;
  end
`endif

  assign bus.o_evt_full      = fifo_full;
  assign bus.o_tx_dv         = (state_q == ST_SEND);
  assign bus.o_tx_byte       = (state_q == ST_SEND || state_q == ST_WAIT) ? frame_q[idx_q] : 8'h00;
  assign bus.o_busy          = (state_q != ST_IDLE) || !fifo_empty;
  assign bus.o_drop_count    = drop_q;
  assign bus.o_timeout_count = tmo_q;
  assign dbg_state           = state_q;

endmodule

// File: tb/tb_resp_framer.sv
// Directed bench for resp_framer: byte scoreboard, latency, overflow, timeout, reset.
module tb_resp_framer;
  import resp_pkg::*;

  localparam int DEPTH = 4;
  localparam int TMO   = 100;
`ifdef RESP_SEQNUM_EN
  localparam int FLEN = 8;
`else
  localparam int FLEN = 7;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  resp_framer_if bus ();
  state_t     dbg_state;
  logic [2:0] dbg_level;

  resp_framer #(.FIFO_DEPTH(DEPTH), .SYNC_BYTE(8'hA5), .DONE_TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_level (dbg_level)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         dv_count = 0;
  logic [7:0] seq_m    = 8'h00;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every strobed byte must match the head of the expected queue
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.o_tx_dv === 1'b1) begin
      dv_count++;
      n_checks++;
      assert (exp_q.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_byte: observed %0h expected none", bus.o_tx_byte);
      end
      if (exp_q.size() != 0) check("tx_byte", {24'h0, bus.o_tx_byte}, {24'h0, exp_q.pop_front()});
    end
  end

  // driver tasks
  task automatic queue_frame(input logic [7:0] code, input logic [31:0] data);
    logic [7:0] c;
    c = code ^ data[31:24] ^ data[23:16] ^ data[15:8] ^ data[7:0];
    exp_q.push_back(8'hA5);
`ifdef RESP_SEQNUM_EN
    exp_q.push_back(seq_m);
    c = c ^ seq_m;
    seq_m = seq_m + 8'd1;
`endif
    exp_q.push_back(code);
    exp_q.push_back(data[31:24]);
    exp_q.push_back(data[23:16]);
    exp_q.push_back(data[15:8]);
    exp_q.push_back(data[7:0]);
    exp_q.push_back(c);
  endtask

  task automatic push_evt(input logic [7:0] code, input logic [31:0] data, input bit accept);
    bus.i_evt_valid = 1'b1;
    bus.i_evt_code  = code;
    bus.i_evt_data  = data;
    if (accept) queue_frame(code, data);
    @(negedge clk);
    bus.i_evt_valid = 1'b0;
  endtask

  task automatic pulse_done();
    bus.i_tx_done = 1'b1;
    @(negedge clk);
    bus.i_tx_done = 1'b0;
  endtask

  task automatic wait_dv(input int max, output int at);
    at = -1;
    for (int i = 0; i < max; i++) begin
      if (bus.o_tx_dv === 1'b1) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    check("dv_within_budget", (at >= 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // Answer nbytes strobes; pos0 is the frame position of the first one.
  task automatic serve(input int nbytes, input int pos0, input int dmin, input int dmax);
    int at;
    int done_cyc;
    done_cyc = 0;
    for (int i = 0; i < nbytes; i++) begin
      wait_dv(300, at);
      if (at < 0) return;
      if (i > 0 && ((pos0 + i) % FLEN) != 0) check("mid_frame_dv_latency", at - done_cyc, 1);
      repeat ($urandom_range(dmax, dmin)) @(negedge clk);
      done_cyc = cyc;
      pulse_done();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.delete();
    seq_m = 8'h00;
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    int at;
    int d0;
    bus.i_evt_valid = 1'b0;
    bus.i_evt_code  = 8'h00;
    bus.i_evt_data  = 32'h0;
    bus.i_tx_done   = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_tx_dv", bus.o_tx_dv, 0);
    check("rst_tx_byte", bus.o_tx_byte, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_full", bus.o_evt_full, 0);
    check("rst_drop", bus.o_drop_count, 0);
    check("rst_tmo", bus.o_timeout_count, 0);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_level", dbg_level, 0);
    reset = 1'b0;
    @(negedge clk);

    // basic frame
    p = cyc;
    push_evt(8'h12, 32'hDEADBEEF, 1'b1);
    wait_dv(10, at);
    check("first_dv_latency", at - p, 3);
    check("first_byte_sync", bus.o_tx_byte, 8'hA5);
    serve(FLEN, 0, 60, 60);
    check("basic_busy_after_done", bus.o_busy, 0);
    check("basic_state_idle", dbg_state, ST_IDLE);
    check("basic_queue_drained", exp_q.size(), 0);

    // overflow: six back-to-back pushes, the sixth is dropped
    for (int i = 0; i < 6; i++) push_evt(8'h20 + 8'(i), $urandom, i < 5);
    check("ovf_full", bus.o_evt_full, 1);
    check("ovf_drop", bus.o_drop_count, 1);
    check("ovf_level", dbg_level, 4);
    check("ovf_state_wait", dbg_state, ST_WAIT);
    pulse_done();
    serve(5 * FLEN - 1, 1, 1, 20);
    check("ovf_queue_drained", exp_q.size(), 0);
    check("ovf_busy", bus.o_busy, 0);

    // timeout: first frame never answered, second must start cleanly
    p = cyc;
    push_evt(8'h31, 32'h01020304, 1'b1);
    push_evt(8'h32, 32'hA0B0C0D0, 1'b1);
    wait_dv(10, at);
    check("tmo_first_dv_latency", at - p, 3);
    @(negedge clk);
    d0 = dv_count;
    repeat (TMO - 1) @(negedge clk);
    check("tmo_not_yet", bus.o_timeout_count, 0);
    check("tmo_still_wait", dbg_state, ST_WAIT);
    @(negedge clk);
    check("tmo_count", bus.o_timeout_count, 1);
    check("tmo_state_idle", dbg_state, ST_IDLE);
    check("tmo_single_strobe", dv_count - d0, 0);
    repeat (FLEN - 1) void'(exp_q.pop_front());
    serve(FLEN, 0, 1, 20);
    check("tmo_queue_drained", exp_q.size(), 0);

    // stray done in IDLE
    pulse_done();
    @(negedge clk);
    check("stray_state", dbg_state, ST_IDLE);
    check("stray_dv", bus.o_tx_dv, 0);
    check("stray_tmo", bus.o_timeout_count, 1);
    check("stray_busy", bus.o_busy, 0);

    // push in the same cycle as LOAD pops with one entry queued
    push_evt(8'h41, 32'h11223344, 1'b1);
    push_evt(8'h42, 32'h55667788, 1'b1);
    serve(FLEN - 1, 0, 1, 10);
    wait_dv(5, at);
    repeat (3) @(negedge clk);
    pulse_done();
    check("sim_state_load", dbg_state, ST_LOAD);
    check("sim_level_before", dbg_level, 1);
    push_evt(8'h43, 32'h99AABBCC, 1'b1);
    check("sim_level_after", dbg_level, 1);
    check("sim_no_drop", bus.o_drop_count, 1);
    check("b2b_sync_strobe", bus.o_tx_dv, 1);
    serve(2 * FLEN, 0, 1, 10);
    check("sim_queue_drained", exp_q.size(), 0);
    check("sim_busy", bus.o_busy, 0);

    // async reset during the third byte
    push_evt(8'h51, 32'hCAFEF00D, 1'b1);
    push_evt(8'h52, 32'h0BADBEEF, 1'b1);
    serve(2, 0, 1, 10);
    wait_dv(5, at);
    #2 reset = 1'b1;
    #1;
    check("arst_dv", bus.o_tx_dv, 0);
    check("arst_byte", bus.o_tx_byte, 0);
    check("arst_drop", bus.o_drop_count, 0);
    check("arst_tmo", bus.o_timeout_count, 0);
    check("arst_level", dbg_level, 0);
    check("arst_state", dbg_state, ST_IDLE);
    check("arst_busy", bus.o_busy, 0);
    exp_q.delete();
    seq_m = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    p = cyc;
    push_evt(8'h12, 32'hDEADBEEF, 1'b1);
    wait_dv(10, at);
    check("post_rst_latency", at - p, 3);
    serve(FLEN, 0, 1, 10);
    check("post_rst_drained", exp_q.size(), 0);

`ifdef RESP_SEQNUM_EN
    // sequence byte wraps after 256 frames
    do_reset();
    for (int f = 0; f < 257; f++) begin
      if (f == 0) push_evt(8'h12, 32'hDEADBEEF, 1'b1);
      else        push_evt(8'($urandom), $urandom, 1'b1);
      serve(FLEN, 0, 1, 2);
    end
    check("seq_queue_drained", exp_q.size(), 0);
    check("seq_model_wrapped", seq_m, 8'h01);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
